// File: rtl/pc_fetch_stage.sv
// Program-counter register and non-pipelined instruction fetch stage.
// One instruction in flight: fetch over req/gnt/rvalid, hand to decode over valid/ready.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_FETCH | request held at pc_q until the memory grants it
// S_WAIT  | request granted, waiting for read data
// S_VALID | instruction presented to decode until accepted
module pc_fetch_stage #(
    parameter int                ADDR_W     = 12,
    parameter int                INSTR_W    = 16,
    parameter logic [ADDR_W-1:0] RESET_PC   = 12'h000,
    parameter logic [ADDR_W-1:0] INT_VECTOR = 12'h004
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  nxt_pc_i,
    input  logic               int_i,
    output logic [ADDR_W-1:0]  current_pc_o,
    output logic               imem_req_o,
    output logic [ADDR_W-1:0]  imem_addr_o,
    input  logic               imem_gnt_i,
    input  logic               imem_rvalid_i,
    input  logic [INSTR_W-1:0] imem_rdata_i,
    output logic [INSTR_W-1:0] instr_o,
    output logic [ADDR_W-1:0]  instr_pc_o,
    output logic               instr_valid_o,
    input  logic               instr_ready_i,
    output logic [ADDR_W-1:0]  epc_o
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_WAIT,
        S_VALID
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q;
    logic [ADDR_W-1:0]   epc_q;
    logic                handshake;

    assign handshake    = (state_q == S_VALID) && instr_ready_i;
    assign current_pc_o = pc_q;
    assign imem_addr_o  = pc_q;
    assign epc_o        = epc_q;

    always_comb begin
        state_d    = state_q;
        // Request is suppressed while reset is held so nothing is issued mid-reset.
        imem_req_o = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_req_o = !rst;
                if (imem_gnt_i) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (imem_rvalid_i) state_d = S_VALID;
            end
            S_VALID: begin
                if (instr_ready_i) state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_FETCH;
            pc_q          <= RESET_PC;
            epc_q         <= '0;
            instr_o       <= '0;
            instr_pc_o    <= '0;
            instr_valid_o <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_WAIT && imem_rvalid_i) begin
                instr_o       <= imem_rdata_i;
                instr_pc_o    <= pc_q;
                instr_valid_o <= 1'b1;
            end
            if (handshake) begin
                instr_valid_o <= 1'b0;
                // Interrupt takes priority; the would-be next PC becomes the return address.
                if (int_i) begin
                    pc_q  <= INT_VECTOR;
                    epc_q <= nxt_pc_i;
                end else begin
                    pc_q  <= nxt_pc_i;
                end
            end
        end
    end

endmodule
